// File: rtl/ook_modulator.sv
// ook_modulator: gates the carrier with framed serial data (start, data LSB first, stop).
// Define OOK_PARITY_EN to insert an odd-parity bit between data and stop.
module ook_modulator #(
  parameter int DATA_W      = 8,
  parameter int CYC_PER_BIT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              carrier_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              mod_out,
  output logic              busy,
  output logic              bit_tick
);

  localparam int EW = (CYC_PER_BIT > 1) ? $clog2(CYC_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [EW-1:0] EDGE_LAST = EW'(CYC_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_EDGE = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
`ifdef OOK_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd5;
`endif

  logic [2:0]        state;
  logic [2:0]        nxt_state;
  logic [EW-1:0]     edge_cnt;
  logic [EW-1:0]     nxt_edge;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     nxt_bitc;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] nxt_shift;
  logic              nxt_busy;
  logic              nxt_tick;
  logic              nxt_bit;
  logic              carrier_d;
  logic              car_edge;
  logic              in_bit;
  logic              bit_end;

`ifdef OOK_PARITY_EN
  logic par_bit;
`endif

  assign car_edge   = carrier_in & ~carrier_d;
  assign in_bit     = (state != S_IDLE) && (state != S_WAIT_EDGE);
  assign bit_end    = in_bit && car_edge && (edge_cnt == EDGE_LAST);
  assign data_ready = (state == S_IDLE);

  always_comb begin
    nxt_state = state;
    nxt_edge  = edge_cnt;
    nxt_bitc  = bit_cnt;
    nxt_shift = shift_reg;
    nxt_busy  = busy;
    nxt_tick  = 1'b0;

    if (in_bit && car_edge) begin
      nxt_edge = bit_end ? '0 : edge_cnt + 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (data_valid) begin
          nxt_state = S_WAIT_EDGE;
          nxt_shift = data_in;
          nxt_busy  = 1'b1;
          nxt_edge  = '0;
          nxt_bitc  = '0;
        end
      end
      S_WAIT_EDGE: begin
        if (car_edge) begin
          nxt_state = S_START;
          nxt_tick  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          nxt_state = S_DATA;
          nxt_tick  = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          nxt_shift = shift_reg >> 1;
          nxt_tick  = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            nxt_bitc  = '0;
`ifdef OOK_PARITY_EN
            nxt_state = S_PARITY;
`else
            nxt_state = S_STOP;
`endif
          end else begin
            nxt_bitc = bit_cnt + 1'b1;
          end
        end
      end
`ifdef OOK_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          nxt_state = S_STOP;
          nxt_tick  = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          nxt_state = S_IDLE;
          nxt_busy  = 1'b0;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_busy  = 1'b0;
      end
    endcase
  end

  // Bit for the period that starts at this edge, so mod_out tracks
  // the carrier with exactly one clock of delay inside each bit.
  always_comb begin
    nxt_bit = 1'b0;
    unique case (nxt_state)
      S_START: nxt_bit = 1'b1;
      S_DATA:  nxt_bit = nxt_shift[0];
`ifdef OOK_PARITY_EN
      S_PARITY: nxt_bit = par_bit;
`endif
      default: nxt_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    carrier_d <= carrier_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      edge_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      busy      <= 1'b0;
      bit_tick  <= 1'b0;
      mod_out   <= 1'b0;
    end else begin
      state     <= nxt_state;
      edge_cnt  <= nxt_edge;
      bit_cnt   <= nxt_bitc;
      shift_reg <= nxt_shift;
      busy      <= nxt_busy;
      bit_tick  <= nxt_tick;
      mod_out   <= carrier_in & nxt_bit;
    end
  end

`ifdef OOK_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (data_valid && data_ready) begin
      par_bit <= ~^data_in;
    end
  end
`endif

endmodule

// File: tb/tb_ook_modulator.sv
// tb_ook_modulator: frame vectors, handshake/reset/stuck-carrier sequences,
// and random traffic checked every cycle against a period-queue model.
module tb_ook_modulator;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int P   = 10;
`ifdef OOK_PARITY_EN
  localparam int NB  = DW + 3;
`else
  localparam int NB  = DW + 2;
`endif
  localparam int LIMIT = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          car = 1'b0;
  logic          dv  = 1'b0;
  logic [DW-1:0] din = '0;
  logic          ready;
  logic          mod;
  logic          busy;
  logic          tick;

  always #5 clk = ~clk;

  ook_modulator #(.DATA_W(DW), .CYC_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .carrier_in(car),
    .data_in(din),
    .data_valid(dv),
    .data_ready(ready),
    .mod_out(mod),
    .busy(busy),
    .bit_tick(tick)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // carrier source, can be stopped low to emulate a stuck generator
  bit car_run = 1'b1;
  int cc = 0;
  always @(posedge clk) begin
    #1;
    if (car_run) begin
      car = (cc < P / 2);
      cc  = (cc + 1) % P;
    end else begin
      car = 1'b0;
      cc  = 0;
    end
  end

  // reference: one queue entry per carrier period of the frame
  bit mq[$];
  bit m_busy = 0, m_tick = 0, m_mod = 0, m_started = 0;
  bit car_prev = 0;
  bit chk_en = 0;

  function automatic void load(input logic [DW-1:0] w);
    bit f[$];
    f.push_back(1'b1);
    for (int i = 0; i < DW; i++) f.push_back(w[i]);
`ifdef OOK_PARITY_EN
    f.push_back(($countones(w) % 2) == 0);
`endif
    f.push_back(1'b0);
    mq.delete();
    foreach (f[i])
      for (int k = 0; k < CPB; k++) mq.push_back(f[i]);
  endfunction

  always @(posedge clk) begin : model
    bit rise;
    rise = car & ~car_prev;
    car_prev = car;
    m_tick = 0;
    if (rst) begin
      mq.delete();
      m_busy = 0;
      m_started = 0;
      m_mod = 0;
    end else if (!m_busy) begin
      m_mod = 0;
      if (dv) begin
        load(din);
        m_busy = 1;
        m_started = 0;
      end
    end else begin
      if (rise && !m_started) begin
        m_started = 1;
        m_tick = 1;
      end else if (rise) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin
          m_busy = 0;
          m_started = 0;
        end else if (mq.size() % CPB == 0) begin
          m_tick = 1;
        end
      end
      m_mod = m_started && car && (mq.size() > 0) && mq[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mod_out", mod, m_mod);
      check("busy", busy, m_busy);
      check("bit_tick", tick, m_tick);
      check("data_ready", ready, !m_busy);
    end
  end

  typedef struct {
    logic [DW-1:0] word;
    logic [9:0]    np;
    logic [10:0]   wp;
  } vec_t;

  vec_t tbl[6];

  function automatic logic expbit(input vec_t v, input int i);
`ifdef OOK_PARITY_EN
    return v.wp[10 - i];
`else
    return v.np[9 - i];
`endif
  endfunction

  task automatic capture(input vec_t v, input logic nxt_dv,
                         input logic [DW-1:0] nxt_din,
                         output int t0, output int t1);
    int ticks = 0;
    int n = 0;
    bit done = 0;
    logic [10:0] obs = '0;
    logic [10:0] want = '0;
    t0 = 0;
    t1 = 0;
    while (!done && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (tick) begin
        ticks++;
        if (ticks == 1) begin
          t0 = cyc;
          dv = nxt_dv;
          din = nxt_din;
        end
      end
      if (ticks > 0 && !busy) begin
        t1 = cyc;
        done = 1;
      end else if (ticks > 0 && ticks <= 11 && mod) begin
        obs[ticks - 1] = 1'b1;
      end
    end
    for (int i = 0; i < NB; i++) want[i] = expbit(v, i);
    check("frame_done", done, 1);
    check("frame_ticks", ticks, NB);
    check("frame_bits", obs, want);
    check("frame_clks", t1 - t0, NB * CPB * P);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", ready, 1);
  endtask

  task automatic send(input vec_t v);
    int t0, t1;
    wait_ready();
    dv = 1'b1;
    din = v.word;
    capture(v, 1'b0, v.word, t0, t1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  initial begin
    int t0a, t1a, t0b, t1b;
    int ticks, k, r, tk, viol;

    tbl[0] = '{8'hA5, 10'b1101001010, 11'b11010010110};
    tbl[1] = '{8'h00, 10'b1000000000, 11'b10000000010};
    tbl[2] = '{8'hFF, 10'b1111111110, 11'b11111111110};
    tbl[3] = '{8'h03, 10'b1110000000, 11'b11100000010};
    tbl[4] = '{8'h07, 10'b1111000000, 11'b11110000000};
    tbl[5] = '{8'h01, 10'b1100000000, 11'b11000000000};

    // reset with carrier running
    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mod", mod, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);

    for (int i = 0; i < 6; i++) send(tbl[i]);

    // valid held high: 00 then FF offered while busy
    wait_ready();
    dv = 1'b1;
    din = 8'h00;
    capture(tbl[1], 1'b1, 8'hFF, t0a, t1a);
    capture(tbl[2], 1'b0, 8'hFF, t0b, t1b);
    check("frame_gap", (t0b - t1a) >= P, 1);

    // reset during data bit 3
    wait_ready();
    dv = 1'b1;
    din = 8'hA5;
    ticks = 0;
    k = 0;
    while (ticks < 5 && k < LIMIT) begin
      @(negedge clk);
      k++;
      if (tick) begin
        ticks++;
        dv = 1'b0;
      end
    end
    check("mid_ticks", ticks, 5);
    repeat (2 * P) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_mod", mod, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ready, 1);
    send(tbl[5]);

    // stuck carrier after accept
    wait_ready();
    car_run = 1'b0;
    dv = 1'b1;
    din = 8'h03;
    @(negedge clk);
    dv = 1'b0;
    viol = 0;
    repeat (300) begin
      @(negedge clk);
      if (!busy || mod || tick) viol++;
    end
    check("stuck_hold", viol, 0);
    car_run = 1'b1;
    k = 0;
    r = -1;
    tk = -1;
    while (tk < 0 && k < LIMIT) begin
      @(negedge clk);
      k++;
      if (tick) tk = k;
      if (car && r < 0) r = k;
    end
    check("resume_start", tk - r, 1);
    wait_idle();

    // random traffic, carrier pauses and resets
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      dv  = ($urandom_range(0, 3) == 0);
      din = DW'($urandom);
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 1999) == 0) car_run = !car_run;
    end
    @(negedge clk);
    rst = 1'b0;
    dv = 1'b0;
    car_run = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
